// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//   Main control unit for the multicycle MIPS datapath. A Moore FSM walks one
//   instruction at a time through fetch, decode, execute, memory and
//   write-back, and drives every enable and mux select of the datapath. An ALU
//   decoder maps the R-type funct field onto alucontrol.
//
//   Parameter MEM_WAIT holds FETCH, MEMRD and MEMWR for MEM_WAIT extra cycles
//   so that slow memory can be used (0 = single-cycle memory).
//
//   Optional feature, macro MC_BNE_EN: when defined, bne (op 000101) is
//   executed in state BNEEX (12). When undefined, bne is an unknown opcode.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   op, funct, zero   IR opcode/function fields and the ALU zero flag
//   pcen              PC enable (pcwrite | branch taken)
//   memwrite, irwrite, regwrite   write strobes (forced low during reset)
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc   datapath mux selects
//   alucontrol        ALU operation (010 = add by default)
//   illegal           one-cycle pulse in DECODE on an unknown opcode
//   state             current state encoding, for debug
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_wait;

    // Raw (ungated) strobes; reset masks them on the way out.
    logic pcwrite, branch, irwrite_r, memwrite_r, regwrite_r, illegal_r;
`ifdef MC_BNE_EN
    logic branch_ne;
`endif

    // The memory states are complete once the counter has reached MEM_WAIT.
    assign last_wait = (cnt_q == CW'(MEM_WAIT));
    assign state     = state_q;

    // Next-state and wait-counter logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_FETCH: begin
                if (last_wait) state_d = S_DECODE;
                else           cnt_d   = cnt_q + 1'b1;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW)      state_d = S_MEMWR;
                else if (op == OP_LW) state_d = S_MEMRD;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (last_wait) state_d = S_MEMWB;
                else           cnt_d   = cnt_q + 1'b1;
            end
            S_MEMWR: begin
                if (last_wait) state_d = S_FETCH;
                else           cnt_d   = cnt_q + 1'b1;
            end
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from state and wait counter.
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_r  = 1'b0;
        memwrite_r = 1'b0;
        regwrite_r = 1'b0;
        illegal_r  = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
`ifdef MC_BNE_EN
        branch_ne  = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                // PC and IR load only once the (possibly stretched) read is done.
                if (last_wait) begin
                    irwrite_r = 1'b1;
                    pcwrite   = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_r = 1'b0;
`ifdef MC_BNE_EN
                    OP_BNE:  illegal_r = 1'b0;
`endif
                    default: illegal_r = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_r = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_r = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;  // add, and unknown funct runs as add
                endcase
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_r = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                branch     = 1'b1;
                pcsrc      = 2'b01;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_r = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                branch_ne  = 1'b1;
                pcsrc      = 2'b01;
            end
`endif
            default: ;
        endcase

`ifdef MC_BNE_EN
        pcen = (pcwrite | (branch & zero) | (branch_ne & ~zero)) & ~reset;
`else
        pcen = (pcwrite | (branch & zero)) & ~reset;
`endif
        memwrite = memwrite_r & ~reset;
        irwrite  = irwrite_r  & ~reset;
        regwrite = regwrite_r & ~reset;
        illegal  = illegal_r  & ~reset;
    end

endmodule
